alu_multi_cycle: RTL and testbench

Parametrised successor to the single-cycle ALU in the primer-ALU bench family. It executes ADD, AND, XOR and SUB in one cycle and MUL over a configurable number of cycles. A start/done/busy handshake lets the UVM driver and monitor sequence mixed single- and multi-cycle operations. The block sits directly behind the bench's operation driver.

---
 rtl/alu_multi_cycle.sv | 135 +++++++++++++
 tb/tb_alu_multi_cycle.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_multi_cycle.sv
// Multi-cycle ALU: ADD/AND/XOR/SUB in one cycle, MUL over MUL_LAT edges, start/done/busy handshake.
// Optional ALU_ERR_EN adds an err pulse for requests rejected as reserved or arriving while busy.
module alu_multi_cycle #(
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
`ifdef ALU_ERR_EN
   output logic                 err,
`endif
   output logic [2*WIDTH-1:0]   result
);

   localparam int RW    = 2 * WIDTH;
   localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } mul_req_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   mul_req_t         mreq;
   logic             mreq_load;
   logic [RW-1:0]    result_nxt;
   logic             done_nxt;
   logic [RW-1:0]    a_ext, b_ext;
   logic [RW-1:0]    alu_res;
   logic [RW-1:0]    mul_res;
   logic             single_op;
   logic             err_nxt;

   assign a_ext   = {{WIDTH{1'b0}}, A};
   assign b_ext   = {{WIDTH{1'b0}}, B};
   assign mul_res = RW'(mreq.a) * RW'(mreq.b);
   assign busy    = (state == S_MUL);

   // SUB wraps modulo 2^RW since both sides are already RW wide
   always_comb begin
      alu_res   = '0;
      single_op = 1'b0;
      case (op)
         OP_ADD: begin alu_res = a_ext + b_ext; single_op = 1'b1; end
         OP_AND: begin alu_res = a_ext & b_ext; single_op = 1'b1; end
         OP_XOR: begin alu_res = a_ext ^ b_ext; single_op = 1'b1; end
         OP_SUB: begin alu_res = a_ext - b_ext; single_op = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mreq_load  = 1'b0;
      result_nxt = result;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (single_op) begin
                  result_nxt = alu_res;
                  done_nxt   = 1'b1;
               end else if (op == OP_MUL) begin
                  state_nxt = S_MUL;
                  cnt_nxt   = CNT_INIT;
                  mreq_load = 1'b1;
               end else if (op != OP_NOP) begin
                  err_nxt = 1'b1;
               end
            end
         end
         S_MUL: begin
            // any request while busy is dropped, including one on the completion edge
            err_nxt = start;
            if (cnt == '0) begin
               state_nxt  = S_IDLE;
               result_nxt = mul_res;
               done_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mreq   <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         result <= result_nxt;
         done   <= done_nxt;
         if (mreq_load) begin
            mreq.a <= A;
            mreq.b <= B;
         end
      end
   end

`ifdef ALU_ERR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err <= 1'b0;
      else          err <= err_nxt;
   end
`else
   logic unused_err;
   assign unused_err = err_nxt;
`endif

endmodule

// File: tb/tb_alu_multi_cycle.sv
// Scoreboard bench for alu_multi_cycle: driver pushes expected completions, negedge monitor pops and checks.
module tb_alu_multi_cycle;

   localparam int WIDTH   = 8;
   localparam int MUL_LAT = 3;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 start = 1'b0;
   logic [2:0]           op = 3'b000;
   logic [WIDTH-1:0]     A = '0;
   logic [WIDTH-1:0]     B = '0;
   logic                 busy, done;
   logic [2*WIDTH-1:0]   result;
`ifdef ALU_ERR_EN
   logic                 err;
`endif

   alu_multi_cycle #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done),
`ifdef ALU_ERR_EN
      .err(err),
`endif
      .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          edge_no;
      logic [15:0] res;
   } exp_t;

   exp_t        exp_q[$];
   int          err_q[$];
   int          edge_cnt = 0;
   int          mul_end  = -1;
   logic [15:0] last_res = '0;
   bit          mon_en   = 1'b0;
   int          n_chk    = 0;
   int          n_fail   = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_cnt, act, exp);
      end
   endtask

   // reference arithmetic straight from the opcode table
   function automatic logic [15:0] model(input logic [2:0] o, input int a, input int b);
      int r;
      case (o)
         3'd1:    r = a + b;
         3'd2:    r = a & b;
         3'd3:    r = a ^ b;
         3'd4:    r = a * b;
         3'd5:    r = a - b;
         default: r = 0;
      endcase
      return 16'(r & 32'hFFFF);
   endfunction

   // drive for the next rising edge and record what the DUT must answer
   task automatic drive(input logic st, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      int  e;
      bit  bsy;
      exp_t x;
      @(negedge clk); #1;
      start = st; op = o; A = a; B = b;
      e   = edge_cnt + 1;
      bsy = (mul_end >= e);
      if (st && !bsy && (o == 3'd1 || o == 3'd2 || o == 3'd3 || o == 3'd5)) begin
         x.edge_no = e; x.res = model(o, a, b);
         exp_q.push_back(x);
      end else if (st && !bsy && o == 3'd4) begin
         x.edge_no = e + MUL_LAT; x.res = model(o, a, b);
         exp_q.push_back(x);
         mul_end = e + MUL_LAT;
      end
      if (st && (bsy || o == 3'd6 || o == 3'd7)) err_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         bit exp_done, exp_err;
         exp_done = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_cnt);
         if (exp_done) begin
            last_res = exp_q[0].res;
            void'(exp_q.pop_front());
         end
         chk("done", 32'(done), 32'(exp_done));
         chk("result", 32'(result), 32'(last_res));
         chk("busy", 32'(busy), 32'(mul_end > edge_cnt));
         exp_err = (err_q.size() > 0) && (err_q[0] == edge_cnt);
         if (exp_err) void'(err_q.pop_front());
`ifdef ALU_ERR_EN
         chk("err", 32'(err), 32'(exp_err));
`endif
      end
   end

   task automatic reset_mid;
      @(negedge clk); #1;
      start = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_result", 32'(result), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_done", 32'(done), 32'h0);
      exp_q.delete();
      err_q.delete();
      mul_end  = -1;
      last_res = '0;
      #1 reset_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      @(negedge clk); #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // single-cycle ADD with carry into the upper byte
      drive(1, 3'd1, 8'hFF, 8'h01);
      drive(0, 3'd0, 8'h00, 8'h00);
      // back-to-back AND, XOR, SUB
      drive(1, 3'd2, 8'hF0, 8'h3C);
      drive(1, 3'd3, 8'hF0, 8'h3C);
      drive(1, 3'd5, 8'h05, 8'h0A);
      drive(0, 3'd0, 8'h00, 8'h00);
      // MUL with requests arriving while busy and on the completion edge
      drive(1, 3'd4, 8'hFF, 8'hFF);
      drive(1, 3'd1, 8'h01, 8'h01);
      drive(0, 3'd1, 8'h01, 8'h01);
      drive(1, 3'd1, 8'h01, 8'h01);
      drive(1, 3'd1, 8'h01, 8'h01);
      drive(0, 3'd0, 8'h00, 8'h00);
      // establish 0x1234, then NOP and reserved opcodes must leave it alone
      drive(1, 3'd4, 8'h14, 8'hE9);
      repeat (MUL_LAT) drive(0, 3'd0, 8'h00, 8'h00);
      drive(1, 3'd0, 8'h11, 8'h22);
      drive(1, 3'd6, 8'h11, 8'h22);
      drive(1, 3'd7, 8'h11, 8'h22);
      drive(0, 3'd0, 8'h00, 8'h00);
      // reset aborts an in-flight multiply
      drive(1, 3'd4, 8'h10, 8'h10);
      drive(0, 3'd0, 8'h00, 8'h00);
      reset_mid();
      drive(1, 3'd1, 8'h02, 8'h03);
      repeat (MUL_LAT + 1) drive(0, 3'd0, 8'h00, 8'h00);

      // randomized mix, operands change freely while busy
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
               8'($urandom), 8'($urandom));
         if ($urandom_range(0, 199) == 0) reset_mid();
      end
      repeat (MUL_LAT + 2) drive(0, 3'd0, 8'h00, 8'h00);
      @(negedge clk); #1;
      chk("drain_exp_q", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
